// File: rtl/edge_arb_pkg.sv
// ----------------------------------------------------------------------------
// edge_arb_pkg
// Shared constants and helpers for the edge event arbiter.
//   DEFAULT_NUM_CH : default channel count
//   id_width()     : width of a channel index for a given channel count
//                    (never less than one bit)
// ----------------------------------------------------------------------------
package edge_arb_pkg;

    localparam int DEFAULT_NUM_CH = 4;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at rr_ptr+1 and wraps,
// so the channel granted last has the lowest priority on the next pick.
// Ports:
//   req       in  [NUM_CH]  request vector
//   rr_ptr    in  [ID_W]    index granted most recently
//   grant     out [NUM_CH]  one-hot grant (all zero when nothing requested)
//   grant_idx out [ID_W]    index of the granted channel
//   any_grant out           at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int NUM_CH = DEFAULT_NUM_CH,
    localparam int ID_W   = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [ID_W-1:0]   grant_idx,
    output logic              any_grant
);

    int idx;

    // Walk offsets from farthest to nearest; the last hit written is the
    // nearest requester after rr_ptr, so no early exit is needed.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = |req;
        idx       = 0;
        for (int off = NUM_CH; off >= 1; off--) begin
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// ----------------------------------------------------------------------------
// edge_event_arbiter
// Collects rising edges on NUM_CH level inputs as pending events and hands
// them one at a time to a single consumer over valid/ready, round-robin.
// Ports:
//   clk        in              clock, all state on rising edge
//   resetn     in              asynchronous active-low reset
//   data_in    in  [NUM_CH]    level inputs
//   ch_enable  in  [NUM_CH]    per-channel enable; 0 ignores edges, flushes pending
//   evt_valid  out             event available
//   evt_id     out [ID_W]      channel index of presented event
//   evt_ready  in              consumer accepts when evt_valid && evt_ready
//   pending    out [NUM_CH]    per-channel pending flags
//   overflow   out [NUM_CH]    sticky lost-event flags
//   ovf_clear  in              clears all overflow bits (a same-cycle set wins)
// Build option:
//   EDGE_ARB_SYNC_EN  when defined, each data_in bit passes a 2-flop
//                     synchronizer before edge detection (inputs may then be
//                     asynchronous; input->evt_valid latency grows by 2).
// ----------------------------------------------------------------------------
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int NUM_CH = DEFAULT_NUM_CH,
    localparam int ID_W   = id_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] data_in,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    input  logic              evt_ready,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    input  logic              ovf_clear
);

    logic [NUM_CH-1:0] data_s;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic              evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]   evt_id_q, evt_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_CH-1:0] edge_w;
    logic [NUM_CH-1:0] req_w;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] granted_w;
    logic [ID_W-1:0]   grant_idx;
    logic              any_grant;
    logic              slot_free;
    logic              do_grant;

`ifdef EDGE_ARB_SYNC_EN
    logic [NUM_CH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    assign data_s = sync2_q;
`else
    assign data_s = data_in;
`endif

    // A disabled channel is masked from arbitration so a flush cannot race
    // with a grant in the same cycle.
    assign req_w = pending_q & ch_enable;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req       (req_w),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign slot_free = !evt_valid_q || evt_ready;
    assign do_grant  = slot_free && any_grant;
    assign granted_w = grant_oh & {NUM_CH{do_grant}};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign edge_w[gi] = data_s[gi] && !prev_q[gi] && ch_enable[gi];

            // A fresh edge beats a same-cycle grant: the channel stays
            // pending for the new event.
            assign pending_d[gi] = !ch_enable[gi] ? 1'b0 :
                                   edge_w[gi]     ? 1'b1 :
                                   granted_w[gi]  ? 1'b0 :
                                                    pending_q[gi];

            // An edge is lost only if the earlier one is still waiting and
            // is not leaving this cycle.
            assign overflow_d[gi] = (edge_w[gi] && pending_q[gi] && !granted_w[gi]) ? 1'b1 :
                                    ovf_clear                                        ? 1'b0 :
                                                                                       overflow_q[gi];
        end
    endgenerate

    // Output slot: reload whenever empty or being consumed.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (slot_free) begin
            if (any_grant) begin
                evt_valid_d = 1'b1;
                evt_id_d    = grant_idx;
                rr_ptr_d    = grant_idx;
            end else begin
                evt_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q      <= '0;
            pending_q   <= '0;
            overflow_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= ID_W'(NUM_CH - 1);
        end else begin
            prev_q      <= data_s;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;

    logic              clk;
    logic              resetn;
    logic [NUM_CH-1:0] data_in;
    logic [NUM_CH-1:0] ch_enable;
    logic              evt_valid;
    logic [ID_W-1:0]   evt_id;
    logic              evt_ready;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overflow;
    logic              ovf_clear;

    int total_cnt;
    int bad_cnt;

    edge_event_arbiter #(
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (data_in),
        .ch_enable (ch_enable),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        resetn    = 1'b0;
        data_in   = '0;
        ch_enable = 4'hF;
        evt_ready = 1'b1;
        ovf_clear = 1'b0;

        // Reset state
        tick();
        check("rst_valid",    32'(evt_valid), 32'h0);
        check("rst_id",       32'(evt_id),    32'h0);
        check("rst_pending",  32'(pending),   32'h0);
        check("rst_overflow", 32'(overflow),  32'h0);
        resetn = 1'b1;
        tick();

        // Single edge on ch0
        data_in = 4'b0001;
        tick();
        check("t1_pending", 32'(pending),   32'h1);
        check("t1_valid0",  32'(evt_valid), 32'h0);
        tick();
        check("t1_valid",   32'(evt_valid), 32'h1);
        check("t1_id",      32'(evt_id),    32'h0);
        check("t1_pend_clr",32'(pending),   32'h0);
        tick();
        check("t1_single",  32'(evt_valid), 32'h0);

        // Burst on all channels from reset: 0,1,2,3
        data_in = '0;
        do_reset();
        tick();
        data_in = 4'b1111;
        tick();
        check("t2_pending", 32'(pending), 32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2_valid%0d", k), 32'(evt_valid), 32'h1);
            check($sformatf("t2_id%0d", k),    32'(evt_id),    32'(k));
        end
        tick();
        check("t2_idle", 32'(evt_valid), 32'h0);

        // Stall with ch2, then overflow
        evt_ready = 1'b0;
        data_in   = '0;
        tick();
        data_in = 4'b0100;
        tick();
        check("t3_pending", 32'(pending), 32'h4);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t3_hold_v%0d", k),  32'(evt_valid), 32'h1);
            check($sformatf("t3_hold_id%0d", k), 32'(evt_id),    32'h2);
        end
        data_in = 4'b0000; tick();
        data_in = 4'b0100; tick();
        check("t3_pend2",    32'(pending),  32'h4);
        check("t3_no_ovf",   32'(overflow), 32'h0);
        data_in = 4'b0000; tick();
        data_in = 4'b0100; tick();
        check("t3_ovf",      32'(overflow), 32'h4);
        evt_ready = 1'b1;
        tick();
        check("t3_next_v",   32'(evt_valid), 32'h1);
        check("t3_next_id",  32'(evt_id),    32'h2);
        tick();
        check("t3_drained",  32'(evt_valid), 32'h0);
        check("t3_ovf_keep", 32'(overflow),  32'h4);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t3_ovf_clr",  32'(overflow),  32'h0);

        // Fairness between ch0 and ch1
        data_in = '0;
        tick();
        data_in = 4'b0011;
        tick();
        check("t4_pending", 32'(pending), 32'h3);
        for (int k = 0; k < 6; k++) begin
            data_in = (k % 2 == 0) ? 4'b0000 : 4'b0011;
            tick();
            check($sformatf("t4_v%0d", k),  32'(evt_valid), 32'h1);
            check($sformatf("t4_id%0d", k), 32'(evt_id),    32'(k % 2));
        end
        data_in = '0;
        tick(); tick(); tick();
        check("t4_idle", 32'(evt_valid), 32'h0);
        check("t4_ovf",  32'(overflow),  32'h0);

        // Disable flushes ch3 pending; disabled edges ignored
        evt_ready = 1'b0;
        data_in   = 4'b0100;
        tick();
        tick();
        check("t5_hold_id", 32'(evt_id), 32'h2);
        data_in = 4'b1100;
        tick();
        check("t5_pend3", 32'(pending), 32'h8);
        ch_enable = 4'b0111;
        tick();
        check("t5_flush",   32'(pending),   32'h0);
        check("t5_keep_v",  32'(evt_valid), 32'h1);
        check("t5_keep_id", 32'(evt_id),    32'h2);
        evt_ready = 1'b1;
        tick();
        check("t5_no_id3", 32'(evt_valid), 32'h0);
        data_in = 4'b0100; tick();
        data_in = 4'b1100; tick();
        tick();
        check("t5_dis_pend",  32'(pending),   32'h0);
        check("t5_dis_valid", 32'(evt_valid), 32'h0);
        check("t5_dis_ovf",   32'(overflow),  32'h0);
        ch_enable = 4'hF;
        data_in   = '0;
        tick();

        // Asynchronous reset mid-burst, then release with inputs high
        data_in = 4'b1111;
        tick();
        tick();
        check("t6_busy", 32'(evt_valid), 32'h1);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_v",   32'(evt_valid), 32'h0);
        check("t6_async_id",  32'(evt_id),    32'h0);
        check("t6_async_pnd", 32'(pending),   32'h0);
        check("t6_async_ovf", 32'(overflow),  32'h0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("t6_no_spur", 32'(evt_valid), 32'h0);
        check("t6_pending", 32'(pending),   32'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6_v%0d", k),  32'(evt_valid), 32'h1);
            check($sformatf("t6_id%0d", k), 32'(evt_id),    32'(k));
        end
        tick();
        check("t6_idle", 32'(evt_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
